// File: rtl/geo_map_mapper_if.sv
// Sample-in / pixel-out bundle between the GPS parser side and the map overlay side.
// The mapper takes the slave view of this bundle.
interface geo_map_mapper_if #(
    parameter int COORD_W = 17,
    parameter int PIX_W   = 9
);
    logic               data_en;
    logic [COORD_W-1:0] lat_num;
    logic [COORD_W-1:0] lon_num;
    logic [PIX_W-1:0]   map_m;
    logic [PIX_W-1:0]   map_n;
    logic               out_valid;
    logic               in_region;
    logic               fix_stale;

    modport master (
        output data_en, lat_num, lon_num,
        input  map_m, map_n, out_valid, in_region, fix_stale
    );

    modport slave (
        input  data_en, lat_num, lon_num,
        output map_m, map_n, out_valid, in_region, fix_stale
    );
endinterface

// File: rtl/geo_map_mapper.sv
// GPS-to-map mapper: moving average, then offset, then shift scaling, then range check.
// Output registers use clamp or hold for off-map fixes; a counter flags stale fixes.
module geo_map_mapper #(
    parameter int COORD_W    = 17,
    parameter int PIX_W      = 9,
    parameter int LAT_OFFSET = 18000,
    parameter int LON_OFFSET = 7000,
    parameter int SHIFT      = 5,
    parameter int MAP_W      = 320,
    parameter int MAP_H      = 240,
    parameter int AVG_LOG    = 2,
    parameter int CLAMP      = 1,
    parameter int TIMEOUT    = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    geo_map_mapper_if.slave bus
);
    localparam int DEPTH  = 1 << AVG_LOG;
    localparam int PTR_W  = (AVG_LOG > 0) ? AVG_LOG : 1;
    localparam int SUM_W  = COORD_W + AVG_LOG;
    localparam int DIFF_W = COORD_W + 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic signed [DIFF_W-1:0] LAT_OFF_S = DIFF_W'(LAT_OFFSET);
    localparam logic signed [DIFF_W-1:0] LON_OFF_S = DIFF_W'(LON_OFFSET);
    localparam logic signed [DIFF_W-1:0] MAP_W_S   = DIFF_W'(MAP_W);
    localparam logic signed [DIFF_W-1:0] MAP_H_S   = DIFF_W'(MAP_H);
    localparam logic [PIX_W-1:0]         M_MAX     = PIX_W'(MAP_W - 1);
    localparam logic [PIX_W-1:0]         N_MAX     = PIX_W'(MAP_H - 1);
    localparam logic [PTR_W-1:0]         PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]         CNT_MAX   = CNT_W'(TIMEOUT);

    // A strobe coinciding with reset is dropped.
    logic accept;
    assign accept = bus.data_en & rst;

    logic [COORD_W-1:0] lat_buf_q [DEPTH];
    logic [COORD_W-1:0] lon_buf_q [DEPTH];
    logic [COORD_W-1:0] lat_old, lon_old;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               filled_q;
    logic [SUM_W-1:0]   lat_sum_q, lat_sum_d, lon_sum_q, lon_sum_d;
    logic               v1_q, v2_q, v3_q;

    if (AVG_LOG == 0) begin : g_old_single
        assign lat_old = lat_buf_q[0];
        assign lon_old = lon_buf_q[0];
    end else begin : g_old_ring
        assign lat_old = lat_buf_q[wr_ptr_q];
        assign lon_old = lon_buf_q[wr_ptr_q];
    end

    always_comb begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (filled_q) begin
            lat_sum_d = lat_sum_q + SUM_W'(bus.lat_num) - SUM_W'(lat_old);
            lon_sum_d = lon_sum_q + SUM_W'(bus.lon_num) - SUM_W'(lon_old);
        end else begin
            lat_sum_d = SUM_W'(bus.lat_num) << AVG_LOG;
            lon_sum_d = SUM_W'(bus.lon_num) << AVG_LOG;
        end
    end

    // An empty ring is prefilled with the first sample so the average never sees stale data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (!filled_q || wr_ptr_q == PTR_W'(i))) begin
                lat_buf_q[i] <= bus.lat_num;
                lon_buf_q[i] <= bus.lon_num;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            filled_q  <= 1'b0;
            lat_sum_q <= '0;
            lon_sum_q <= '0;
            v1_q      <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                wr_ptr_q  <= wr_ptr_d;
                filled_q  <= 1'b1;
                lat_sum_q <= lat_sum_d;
                lon_sum_q <= lon_sum_d;
            end
        end
    end

    logic [COORD_W-1:0]       lat_avg, lon_avg;
    logic signed [DIFF_W-1:0] lat_diff_d, lon_diff_d, lat_diff_q, lon_diff_q;
    logic signed [DIFF_W-1:0] lat_scaled, lon_scaled;
    logic                     m_lo_d, m_hi_d, n_lo_d, n_hi_d;
    logic                     m_lo_q, m_hi_q, n_lo_q, n_hi_q;
    logic [PIX_W-1:0]         m_pix_q, n_pix_q;

    assign lat_avg    = lat_sum_q[AVG_LOG +: COORD_W];
    assign lon_avg    = lon_sum_q[AVG_LOG +: COORD_W];
    assign lat_diff_d = $signed({1'b0, lat_avg}) - LAT_OFF_S;
    assign lon_diff_d = $signed({1'b0, lon_avg}) - LON_OFF_S;

    assign lat_scaled = lat_diff_q >>> SHIFT;
    assign lon_scaled = lon_diff_q >>> SHIFT;
    assign m_lo_d     = lat_scaled[DIFF_W-1];
    assign n_lo_d     = lon_scaled[DIFF_W-1];
    assign m_hi_d     = lat_scaled >= MAP_W_S;
    assign n_hi_d     = lon_scaled >= MAP_H_S;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            lat_diff_q <= '0;
            lon_diff_q <= '0;
            m_lo_q     <= 1'b0;
            m_hi_q     <= 1'b0;
            n_lo_q     <= 1'b0;
            n_hi_q     <= 1'b0;
            m_pix_q    <= '0;
            n_pix_q    <= '0;
        end else begin
            v2_q       <= v1_q;
            v3_q       <= v2_q;
            lat_diff_q <= lat_diff_d;
            lon_diff_q <= lon_diff_d;
            m_lo_q     <= m_lo_d;
            m_hi_q     <= m_hi_d;
            n_lo_q     <= n_lo_d;
            n_hi_q     <= n_hi_d;
            m_pix_q    <= lat_scaled[PIX_W-1:0];
            n_pix_q    <= lon_scaled[PIX_W-1:0];
        end
    end

    logic [PIX_W-1:0] map_m_q, map_m_d, map_n_q, map_n_d;
    logic             out_valid_q, in_region_q, in_region_d;
    logic             fix_stale_q, fix_stale_d;
    logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;
    logic             in_reg;

    assign in_reg = !m_lo_q && !m_hi_q && !n_lo_q && !n_hi_q;

    always_comb begin
        map_m_d     = map_m_q;
        map_n_d     = map_n_q;
        in_region_d = in_region_q;
        if (v3_q) begin
            in_region_d = in_reg;
            if (CLAMP != 0) begin
                map_m_d = m_lo_q ? '0 : (m_hi_q ? M_MAX : m_pix_q);
                map_n_d = n_lo_q ? '0 : (n_hi_q ? N_MAX : n_pix_q);
            end else if (in_reg) begin
                map_m_d = m_pix_q;
                map_n_d = n_pix_q;
            end
        end
    end

    // A fresh output clears staleness, and wins over a coincident timeout.
    always_comb begin
        stale_cnt_d = accept ? '0
                    : (stale_cnt_q == CNT_MAX ? stale_cnt_q : stale_cnt_q + 1'b1);
        fix_stale_d = fix_stale_q;
        if (v3_q) begin
            fix_stale_d = 1'b0;
        end else if (stale_cnt_d == CNT_MAX) begin
            fix_stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            map_m_q     <= '0;
            map_n_q     <= '0;
            out_valid_q <= 1'b0;
            in_region_q <= 1'b0;
            fix_stale_q <= 1'b1;
            stale_cnt_q <= CNT_MAX;
        end else begin
            map_m_q     <= map_m_d;
            map_n_q     <= map_n_d;
            out_valid_q <= v3_q;
            in_region_q <= in_region_d;
            fix_stale_q <= fix_stale_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign bus.map_m     = map_m_q;
    assign bus.map_n     = map_n_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_region = in_region_q;
    assign bus.fix_stale = fix_stale_q;
endmodule

// File: tb/tb_geo_map_mapper.sv
// Three mapper configurations (clamp, hold, 4-deep average) share one stimulus stream.
// A behavioural model queues expected results, which are checked every cycle on the falling edge.
module tb_geo_map_mapper;
    localparam int TMO     = 16;
    localparam int LAT_OFF = 18000;
    localparam int LON_OFF = 7000;
    localparam int SH      = 5;
    localparam int MW      = 320;
    localparam int MH      = 240;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        de_r = 1'b0;
    logic [16:0] lat_r = '0;
    logic [16:0] lon_r = '0;

    always #5 clk = ~clk;

    geo_map_mapper_if #(.COORD_W(17), .PIX_W(9)) bus_a ();
    geo_map_mapper_if #(.COORD_W(17), .PIX_W(9)) bus_h ();
    geo_map_mapper_if #(.COORD_W(17), .PIX_W(9)) bus_v ();

    assign bus_a.data_en = de_r;
    assign bus_a.lat_num = lat_r;
    assign bus_a.lon_num = lon_r;
    assign bus_h.data_en = de_r;
    assign bus_h.lat_num = lat_r;
    assign bus_h.lon_num = lon_r;
    assign bus_v.data_en = de_r;
    assign bus_v.lat_num = lat_r;
    assign bus_v.lon_num = lon_r;

    geo_map_mapper #(.AVG_LOG(0), .CLAMP(1), .TIMEOUT(TMO)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    geo_map_mapper #(.AVG_LOG(0), .CLAMP(0), .TIMEOUT(TMO)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
    geo_map_mapper #(.AVG_LOG(2), .CLAMP(1), .TIMEOUT(TMO)) dut_v (.clk(clk), .rst(rst), .bus(bus_v));

    logic [8:0] om [3];
    logic [8:0] on_ [3];
    logic       ov [3];
    logic       oi [3];
    logic       os [3];

    assign om[0]  = bus_a.map_m;
    assign om[1]  = bus_h.map_m;
    assign om[2]  = bus_v.map_m;
    assign on_[0] = bus_a.map_n;
    assign on_[1] = bus_h.map_n;
    assign on_[2] = bus_v.map_n;
    assign ov[0]  = bus_a.out_valid;
    assign ov[1]  = bus_h.out_valid;
    assign ov[2]  = bus_v.out_valid;
    assign oi[0]  = bus_a.in_region;
    assign oi[1]  = bus_h.in_region;
    assign oi[2]  = bus_v.in_region;
    assign os[0]  = bus_a.fix_stale;
    assign os[1]  = bus_h.fix_stale;
    assign os[2]  = bus_v.fix_stale;

    typedef struct packed {
        int               due;
        logic [2:0][31:0] sm;
        logic [2:0][31:0] sn;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int dep [3]    = '{1, 1, 4};
    bit clampk [3] = '{1'b1, 1'b0, 1'b1};
    int hl [3][4];
    int hn [3][4];
    int hp [3];
    bit filled [3];
    int pm [3];
    int pn [3];
    bit pin [3];
    bit ov_exp = 1'b0;
    bit stale_exp = 1'b1;
    bit de_seen = 1'b0;
    int last_de = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Floor division by 2^SH, written independently of any shift operator.
    function automatic int fdiv(input int a);
        int d;
        d = 1 << SH;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic model_accept(input int lat, input int lon);
        exp_t e;
        e.due = cyc + 3;
        for (int k = 0; k < 3; k++) begin
            int sl;
            int sn;
            if (!filled[k]) begin
                for (int i = 0; i < dep[k]; i++) begin
                    hl[k][i] = lat;
                    hn[k][i] = lon;
                end
                hp[k] = 1 % dep[k];
                filled[k] = 1'b1;
            end else begin
                hl[k][hp[k]] = lat;
                hn[k][hp[k]] = lon;
                hp[k] = (hp[k] + 1) % dep[k];
            end
            sl = 0;
            sn = 0;
            for (int i = 0; i < dep[k]; i++) begin
                sl += hl[k][i];
                sn += hn[k][i];
            end
            e.sm[k] = 32'(fdiv(sl / dep[k] - LAT_OFF));
            e.sn[k] = 32'(fdiv(sn / dep[k] - LON_OFF));
        end
        sb.push_back(e);
    endtask

    task automatic model_pop(input exp_t e);
        for (int k = 0; k < 3; k++) begin
            int m;
            int n;
            bit inr;
            m = int'($signed(e.sm[k]));
            n = int'($signed(e.sn[k]));
            inr = (m >= 0) && (m < MW) && (n >= 0) && (n < MH);
            if (clampk[k]) begin
                pm[k] = (m < 0) ? 0 : ((m >= MW) ? MW - 1 : m);
                pn[k] = (n < 0) ? 0 : ((n >= MH) ? MH - 1 : n);
            end else if (inr) begin
                pm[k] = m;
                pn[k] = n;
            end
            pin[k] = inr;
        end
        $display("cycle %0d out: clamp=(%0d,%0d,%0d) hold=(%0d,%0d,%0d) avg=(%0d,%0d,%0d)",
                 cyc, pm[0], pn[0], pin[0], pm[1], pn[1], pin[1], pm[2], pn[2], pin[2]);
    endtask

    task automatic model_edge(input bit r, input bit de, input int lat, input int lon);
        exp_t e;
        ov_exp = 1'b0;
        if (!r) begin
            sb.delete();
            for (int k = 0; k < 3; k++) begin
                filled[k] = 1'b0;
                hp[k] = 0;
                pm[k] = 0;
                pn[k] = 0;
                pin[k] = 1'b0;
            end
            stale_exp = 1'b1;
            de_seen = 1'b0;
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                model_pop(e);
                ov_exp = 1'b1;
            end
            if (de) begin
                model_accept(lat, lon);
                last_de = cyc;
                de_seen = 1'b1;
            end
            if (ov_exp) stale_exp = 1'b0;
            else if (de_seen && (cyc - last_de >= TMO)) stale_exp = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(ov_exp));
            check($sformatf("map_m[%0d]", k), int'(om[k]), pm[k]);
            check($sformatf("map_n[%0d]", k), int'(on_[k]), pn[k]);
            check($sformatf("in_region[%0d]", k), int'(oi[k]), int'(pin[k]));
            check($sformatf("fix_stale[%0d]", k), int'(os[k]), int'(stale_exp));
        end
    endtask

    task automatic step(input bit r, input bit de, input int lat, input int lon);
        rst   = r;
        de_r  = de;
        lat_r = 17'(lat);
        lon_r = 17'(lon);
        @(posedge clk);
        cyc++;
        model_edge(r, de, lat, lon);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic sample(input int lat, input int lon);
        step(1'b1, 1'b1, lat, lon);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int pct;
        do_reset(3);
        idle(2);

        // basic mapping
        sample(21200, 8600);
        idle(4);
        check("basic_m", int'(om[0]), 100);
        check("basic_n", int'(on_[0]), 50);
        check("basic_in", int'(oi[0]), 1);
        check("basic_stale", int'(os[0]), 0);

        // underflow on m, overflow on n
        sample(17000, 14680);
        idle(4);
        check("clamp_lo_m", int'(om[0]), 0);
        check("clamp_hi_n", int'(on_[0]), 239);
        check("clamp_in", int'(oi[0]), 0);
        check("hold_m", int'(om[1]), 100);
        check("hold_n", int'(on_[1]), 50);
        check("hold_in", int'(oi[1]), 0);

        sample(28240, 8600);
        idle(4);
        check("clamp_hi_m", int'(om[0]), 319);

        // averaging with pointer wrap
        do_reset(2);
        sample(21200, 8600);
        idle(4);
        check("avg_first", int'(om[2]), 100);
        for (int i = 0; i < 4; i++) sample(21328, 8600);
        idle(3);
        check("avg_full", int'(om[2]), 104);
        sample(21200, 8600);
        idle(4);
        check("avg_wrap", int'(om[2]), 103);

        // stale timeout
        idle(20);
        check("stale_set", int'(os[0]), 1);

        // reset with a sample in flight
        sample(21328, 8600);
        do_reset(1);
        idle(4);
        check("midrst_m", int'(om[2]), 0);
        check("midrst_stale", int'(os[2]), 1);
        sample(21200, 8600);
        idle(4);
        check("midrst_prefill", int'(om[2]), 100);

        // random traffic with varying density and occasional resets
        pct = 80;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) pct = (i % 150 == 0) ? 80 : ((i % 150 == 50) ? 20 : 2);
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 99) < pct),
                 int'($urandom_range(10000, 40000)),
                 int'($urandom_range(4000, 16000)));
        end
        idle(25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/geo_map_mapper.md
# geo_map_mapper

Parametrised GPS-to-map coordinate mapper: latches scaled integer latitude/longitude samples, smooths them with a power-of-two moving average, and converts them to map pixel coordinates with offset, arithmetic shift scaling, and signed range checking. It also provides clamp or hold handling of out-of-map fixes and a stale-fix timeout. It sits between the GPS parser and the map/LCD overlay logic. Latitude maps to the m axis, longitude to the n axis.

## Interface
- COORD_W, 17, width of unsigned input coordinates
- PIX_W, 9, width of map pixel outputs
- LAT_OFFSET, 18000, latitude value mapped to m = 0
- LON_OFFSET, 7000, longitude value mapped to n = 0
- SHIFT, 5, scale divisor is 2^SHIFT
- MAP_W, 320, valid m range 0..MAP_W-1
- MAP_H, 240, valid n range 0..MAP_H-1
- AVG_LOG, 2, moving-average depth 2^AVG_LOG; 0 bypasses averaging
- CLAMP, 1, out-of-map policy: 1 clamps to the nearest edge, 0 holds the last outputs
- TIMEOUT, 50000000, cycles without data_en before fix_stale asserts
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous reset, active-low
- data_en  in  1  one-cycle strobe; lat_num/lon_num valid; accepted every cycle, no backpressure
- lat_num  in  COORD_W  scaled latitude sample
- lon_num  in  COORD_W  scaled longitude sample
- map_m  out  PIX_W  latitude pixel coordinate
- map_n  out  PIX_W  longitude pixel coordinate
- out_valid  out  1  one-cycle pulse; map_m/map_n/in_region updated this cycle
- in_region  out  1  1 when the last processed sample fell inside the map
- fix_stale  out  1  1 when no sample has been received for TIMEOUT cycles, or none since reset

## Operation
- **Stage 1 (accept):** on data_en, write the sample into a circular buffer of 2^AVG_LOG entries per axis and update running sums (width COORD_W+AVG_LOG) as sum + new - oldest.
  - The first sample after reset prefills every entry, so the sum equals the sample << AVG_LOG. There is no partial-fill averaging.
  - The write pointer wraps modulo 2^AVG_LOG.
- **Stage 2 (offset):** avg = sum >> AVG_LOG (truncate). diff = {1'b0, avg} - OFFSET, computed signed at COORD_W+1 bits.
- **Stage 3 (scale/check):** scaled = diff >>> SHIFT (arithmetic, floor toward -inf). An axis is valid iff scaled >= 0 and scaled < MAP_W (m) or MAP_H (n). in_region = m_valid & n_valid.
- **Out-of-map policy, CLAMP=1:** an axis with scaled < 0 outputs 0; scaled >= limit outputs limit-1; a valid axis outputs scaled[PIX_W-1:0].
- **Out-of-map policy, CLAMP=0:** if in_region = 0, map_m and map_n keep their previous values. Either way, in_region and out_valid still update.
- **Stale counter:**
  - Reset value TIMEOUT.
  - Cleared to 0 on data_en; otherwise increments, saturating at TIMEOUT.
  - fix_stale is set the cycle the counter reaches TIMEOUT and cleared in the cycle out_valid pulses.
  - If both occur in the same cycle, clearing wins.
- **Reset (rst = 0 at a clock edge):** all pipeline valid bits clear; samples in flight are discarded and produce no out_valid. The buffer is marked empty, so the next sample prefills.
- **Reset values:** map_m = 0, map_n = 0, out_valid = 0, in_region = 0, fix_stale = 1.

## Timing
- data_en sampled at edge t produces out_valid = 1 during cycle t+3, with outputs updated at the same edge.
- Fixed latency of 3 cycles, independent of AVG_LOG.
- Throughput is 1 sample per cycle. Back-to-back data_en yields back-to-back out_valid pulses in the same order.
- map_m, map_n and in_region are registered and stable between out_valid pulses.
- fix_stale asserts exactly TIMEOUT cycles after the last data_en edge, provided no out_valid occurs in between.
- Deasserting rst takes effect at the first following edge. data_en in the same cycle as rst = 0 is ignored.

## Test plan
- **Basic mapping** (AVG_LOG=0, CLAMP=1): lat=21200, lon=8600 -> at t+3, out_valid=1, map_m=100, map_n=50, in_region=1, fix_stale=0.
- **Underflow and overflow clamp:** lat=17000 (diff -1000, scaled -32), lon=14680 (scaled 240) -> map_m=0, map_n=239, in_region=0. Next, lat=28240 -> map_m=319.
- **Hold mode** (CLAMP=0): in-region sample m=100/n=50, then lat=17000 -> out_valid=1, in_region=0, map_m=100, map_n=50 unchanged.
- **Averaging** (AVG_LOG=2): first lat=21200 -> m=100. Then four data_en with lat=21328 -> m sequence 101, 102, 103, 104. Pointer wrap is verified by a fifth sample of 21200 -> m=103.
- **Stale** (TIMEOUT=16): after reset fix_stale=1. data_en at t -> fix_stale=0 at t+3. No further data_en -> fix_stale=1 at t+16.
- **Reset mid-flight:** data_en at t, rst=0 at t+1 -> no out_valid. All outputs return to reset values; the next sample prefills the buffer.
